// File: rtl/spi_dac_responder.sv
// SPI mode-0 responder: captures each chip-select frame in the clk domain, reports the active select,
// and shifts the previous frame back out on Miso for readback.
module spi_dac_responder #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned NCS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Sck,
    input  logic             Mosi,
    input  logic [NCS-1:0]   nCs,
    output logic             Miso,
    output logic [WIDTH-1:0] FrameData,
    output logic [1:0]       FrameCs,
    output logic             FrameValid,
    output logic             FrameError,
    output logic [15:0]      FrameCount
);

    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

    state_t state, state_n;

    logic           sck_s1, sck_s2, sck_d;
    logic           mosi_s1, mosi_s2;
    logic [NCS-1:0] ncs_s1, ncs_s2, ncs_d;
    logic [1:0]     fill;
    logic           armed;

    logic [WIDTH-1:0] shift_reg, shift_n, tx_reg, tx_n, data_n;
    logic [CW-1:0]    bit_cnt, cnt_n;
    logic [1:0]       cur_cs, cur_cs_n, fcs_n;
    logic [15:0]      count_n;
    logic             valid_n, error_n;

    logic           sck_rise, sck_fall, ncs_all_high, ncs_was_high;
    logic [2:0]     low_cnt;
    logic [1:0]     low_idx;
    logic [NCS-1:0] cs_pattern;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ncs_s1  <= '1;
            ncs_s2  <= '1;
            ncs_d   <= '1;
            fill    <= '0;
            armed   <= 1'b0;
        end else begin
            sck_s1  <= Sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= Mosi;
            mosi_s2 <= mosi_s1;
            ncs_s1  <= nCs;
            ncs_s2  <= ncs_s1;
            ncs_d   <= ncs_s2;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
            // Only arm once real pin data has reached the edge register and shows all selects high,
            // so a frame already running when reset released is never mistaken for a new select.
            if (fill == 2'd3 && ncs_was_high)
                armed <= 1'b1;
        end
    end

    assign sck_rise     = sck_s2 & ~sck_d;
    assign sck_fall     = ~sck_s2 & sck_d;
    assign ncs_all_high = &ncs_s2;
    assign ncs_was_high = &ncs_d;
    assign cs_pattern   = ~(NCS'(1) << cur_cs);

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int unsigned i = 0; i < NCS; i++) begin
            if (!ncs_s2[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift_reg;
        cnt_n    = bit_cnt;
        tx_n     = tx_reg;
        cur_cs_n = cur_cs;
        data_n   = FrameData;
        fcs_n    = FrameCs;
        count_n  = FrameCount;
        valid_n  = 1'b0;
        error_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && ncs_was_high && !ncs_all_high) begin
                    if (low_cnt == 3'd1) begin
                        cur_cs_n = low_idx;
                        shift_n  = '0;
                        cnt_n    = '0;
                        tx_n     = FrameData;
                        state_n  = SHIFT;
                    end else begin
                        error_n = 1'b1;
                        state_n = WAIT;
                    end
                end
            end
            SHIFT: begin
                // End of frame takes priority over an Sck edge seen in the same sample.
                if (ncs_all_high) begin
                    if (bit_cnt == CW'(WIDTH)) begin
                        data_n  = shift_reg;
                        fcs_n   = cur_cs;
                        count_n = FrameCount + 16'd1;
                        valid_n = 1'b1;
                    end else begin
                        error_n = 1'b1;
                    end
                    state_n = IDLE;
                end else if (ncs_s2 != cs_pattern) begin
                    error_n = 1'b1;
                    state_n = WAIT;
                end else begin
                    if (sck_rise) begin
                        shift_n = {shift_reg[WIDTH-2:0], mosi_s2};
                        if (bit_cnt != CW'(WIDTH + 1))
                            cnt_n = bit_cnt + 1'b1;
                    end
                    if (sck_fall)
                        tx_n = {tx_reg[WIDTH-2:0], 1'b0};
                end
            end
            WAIT: begin
                if (ncs_all_high)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tx_reg     <= '0;
            cur_cs     <= '0;
            FrameData  <= '0;
            FrameCs    <= '0;
            FrameCount <= '0;
            FrameValid <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= cnt_n;
            tx_reg     <= tx_n;
            cur_cs     <= cur_cs_n;
            FrameData  <= data_n;
            FrameCs    <= fcs_n;
            FrameCount <= count_n;
            FrameValid <= valid_n;
            FrameError <= error_n;
        end
    end

    // Zero fill in tx_reg makes Miso fall to 0 once all WIDTH bits have been shifted out.
    assign Miso = (state == SHIFT) & tx_reg[WIDTH-1];

endmodule

// File: tb/tb_spi_dac_responder.sv
// Directed-vector bench for spi_dac_responder: a frame-level model predicts pulses and captured
// values from what the bench master sends; a compare loop checks them every clk.
module tb_spi_dac_responder;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned NCS   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Sck = 1'b0;
    logic             Mosi = 1'b0;
    logic [NCS-1:0]   nCs = '1;
    logic             Miso;
    logic [WIDTH-1:0] FrameData;
    logic [1:0]       FrameCs;
    logic             FrameValid;
    logic             FrameError;
    logic [15:0]      FrameCount;

    spi_dac_responder #(.WIDTH(WIDTH), .NCS(NCS)) dut (
        .clk(clk), .rst(rst), .Sck(Sck), .Mosi(Mosi), .nCs(nCs), .Miso(Miso),
        .FrameData(FrameData), .FrameCs(FrameCs), .FrameValid(FrameValid),
        .FrameError(FrameError), .FrameCount(FrameCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: one pending frame outcome, due at a given cycle.
    int               pend_at = -1;
    bit               pend_valid = 1'b0;
    logic [WIDTH-1:0] pend_data = '0;
    logic [1:0]       pend_cs = '0;
    logic [WIDTH-1:0] exp_data = '0;
    logic [1:0]       exp_cs = '0;
    logic [15:0]      exp_count = '0;
    int               valid_seen = 0;
    int               error_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_loop();
        bit ev, ee;
        forever begin
            @(posedge clk);
            #1;
            ev = 1'b0;
            ee = 1'b0;
            if (rst) begin
                exp_data  = '0;
                exp_cs    = '0;
                exp_count = '0;
            end else if (cyc == pend_at) begin
                if (pend_valid) begin
                    ev        = 1'b1;
                    exp_data  = pend_data;
                    exp_cs    = pend_cs;
                    exp_count = exp_count + 16'd1;
                end else begin
                    ee = 1'b1;
                end
            end
            if (FrameValid === 1'b1) valid_seen++;
            if (FrameError === 1'b1) error_seen++;
            check("FrameValid", 32'(FrameValid), 32'(ev));
            check("FrameError", 32'(FrameError), 32'(ee));
            check("FrameData", 32'(FrameData), 32'(exp_data));
            check("FrameCs", 32'(FrameCs), 32'(exp_cs));
            check("FrameCount", 32'(FrameCount), 32'(exp_count));
            if (rst || nCs == '1) check("Miso_idle", 32'(Miso), 32'd0);
        end
    endtask

    // Mode-0 master, Sck = clk/8; rst_after > 0 pulses reset after that many bits.
    task automatic frame(input int cs, input logic [31:0] data, input int nbits,
                         input int rst_after, output logic [31:0] rb);
        logic [31:0]      exp_rb;
        logic [WIDTH-1:0] snap;
        snap   = exp_data;
        rb     = '0;
        exp_rb = '0;
        @(negedge clk);
        nCs[cs] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            Mosi = data[nbits-1-i];
            repeat (4) @(negedge clk);
            rb     = {rb[30:0], Miso};
            exp_rb = {exp_rb[30:0], (i < int'(WIDTH)) ? snap[int'(WIDTH)-1-i] : 1'b0};
            Sck = 1'b1;
            repeat (4) @(negedge clk);
            Sck = 1'b0;
            if (i + 1 == rst_after) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        nCs = '1;
        if (rst_after == 0) begin
            pend_at    = cyc + 3;
            pend_valid = (nbits == int'(WIDTH));
            pend_data  = data[WIDTH-1:0];
            pend_cs    = cs[1:0];
        end
        repeat (8) @(negedge clk);
        if (rst_after == 0) check("readback", rb, exp_rb);
    endtask

    task automatic run_tests();
        logic [31:0] rb;
        int v0, e0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_data", 32'(FrameData), 32'h0);
        check("reset_count", 32'(FrameCount), 32'h0);
        check("reset_miso", 32'(Miso), 32'h0);

        // First frame on nCs[2].
        frame(2, 32'hA5C3E1, 24, 0, rb);
        check("t1_data", 32'(FrameData), 32'hA5C3E1);
        check("t1_cs", 32'(FrameCs), 32'd2);
        check("t1_count", 32'(FrameCount), 32'd1);
        check("t1_valid_pulses", 32'(valid_seen), 32'd1);
        check("t1_error_pulses", 32'(error_seen), 32'd0);

        // Second frame reads back the first.
        frame(0, 32'h123456, 24, 0, rb);
        check("t2_readback", rb, 32'hA5C3E1);
        check("t2_data", 32'(FrameData), 32'h123456);
        check("t2_cs", 32'(FrameCs), 32'd0);
        check("t2_count", 32'(FrameCount), 32'd2);

        // Short and long frames are rejected.
        frame(1, 32'h7ABCDE, 23, 0, rb);
        frame(3, 32'h1FEDCBA, 25, 0, rb);
        check("t3_error_pulses", 32'(error_seen), 32'd2);
        check("t3_data", 32'(FrameData), 32'h123456);
        check("t3_count", 32'(FrameCount), 32'd2);

        // Two selects falling together.
        v0 = valid_seen;
        e0 = error_seen;
        @(negedge clk);
        nCs[1] = 1'b0;
        nCs[3] = 1'b0;
        pend_at    = cyc + 3;
        pend_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            Mosi = 1'b1;
            repeat (4) @(negedge clk);
            Sck = 1'b1;
            repeat (4) @(negedge clk);
            Sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        nCs = '1;
        repeat (8) @(negedge clk);
        check("t4_error_pulses", 32'(error_seen - e0), 32'd1);
        check("t4_valid_pulses", 32'(valid_seen - v0), 32'd0);
        frame(1, 32'h00000F, 24, 0, rb);
        check("t4_data", 32'(FrameData), 32'h00000F);
        check("t4_cs", 32'(FrameCs), 32'd1);
        check("t4_count", 32'(FrameCount), 32'd3);

        // Counter wrap.
        @(negedge clk);
        force dut.FrameCount = 16'hFFFF;
        exp_count = 16'hFFFF;
        @(negedge clk);
        release dut.FrameCount;
        v0 = valid_seen;
        frame(2, 32'hC0FFEE, 24, 0, rb);
        check("t5_count_wrap", 32'(FrameCount), 32'h0);
        check("t5_valid_pulses", 32'(valid_seen - v0), 32'd1);
        check("t5_data", 32'(FrameData), 32'hC0FFEE);

        // Reset after 10 bits, frame then runs to completion at the pins.
        v0 = valid_seen;
        e0 = error_seen;
        frame(1, 32'h5A5A5A, 24, 10, rb);
        check("t6_valid_pulses", 32'(valid_seen - v0), 32'd0);
        check("t6_error_pulses", 32'(error_seen - e0), 32'd0);
        check("t6_data", 32'(FrameData), 32'h0);
        check("t6_cs", 32'(FrameCs), 32'h0);
        check("t6_count", 32'(FrameCount), 32'h0);
        frame(0, 32'h3C3C3C, 24, 0, rb);
        check("t6_readback", rb, 32'h0);
        check("t6_next_data", 32'(FrameData), 32'h3C3C3C);
        check("t6_next_count", 32'(FrameCount), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            compare_loop();
            run_tests();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
